seq_detector_param: RTL and testbench

- Parametrised Mealy serial-pattern detector; successor to the fixed-pattern 3-bit-state detectors in the FSM library.
- Pattern length and reset pattern are generics; the pattern can be reloaded at run time.
- Overlapping or non-overlapping mode is selected by parameter; input samples are qualified by a valid strobe.
- Sits between a serial bit source and downstream control logic, and replaces the hand-coded per-pattern detectors.

---
 rtl/seq_detector_param.sv | 125 ++++++++++++
 tb/tb_seq_detector_param.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param
// Parametrised Mealy serial-pattern detector with a reloadable pattern.
// The window is the last SEQ_LEN-1 accepted bits followed by the current x;
// Y is raised combinationally in the cycle the final pattern bit arrives.
// OVERLAP selects whether the tail of one match may start the next match.
// Optional feature macro: SEQ_DET_MATCH_CNT_EN (saturating match counter).
// When the macro is undefined, match_cnt is tied to zero and cnt_clr is ignored.

module seq_detector_param #(
   parameter int                 SEQ_LEN  = 4,
   parameter logic [SEQ_LEN-1:0] SEQ_INIT = 4'b1010,
   parameter bit                 OVERLAP  = 1'b1,
   parameter int                 CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               x,
   input  logic               x_valid,
   input  logic               pat_load,
   input  logic [SEQ_LEN-1:0] pat_in,
   input  logic               cnt_clr,
   output logic               Y,
   output logic [SEQ_LEN-1:0] pattern,
   output logic [CNT_W-1:0]   match_cnt
);

   // fill counts accepted bits since the last clear and stops at SEQ_LEN-1,
   // at which point the window holds a full pattern's worth of bits
   localparam int                FILL_W   = $clog2(SEQ_LEN);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN - 1);

   logic [SEQ_LEN-1:0] pattern_reg, pattern_next;
   logic [SEQ_LEN-2:0] hist_reg, hist_next;
   logic [FILL_W-1:0]  fill_reg, fill_next;

   logic [SEQ_LEN-1:0] window;
   logic [SEQ_LEN-1:0] eq_bits;
   logic               accept;
   logic               full;
   logic               match;

   // newest bit sits in the LSB so the oldest history bit lines up with the pattern MSB
   assign window = {hist_reg, x};

   // per-bit equality between the live window and the stored pattern
   generate
      for (genvar gi = 0; gi < SEQ_LEN; gi++) begin : g_eq
         assign eq_bits[gi] = ~(window[gi] ^ pattern_reg[gi]);
      end
   endgenerate

   // a pattern load discards the sample presented in the same cycle
   assign accept = x_valid & ~pat_load;
   assign full   = (fill_reg == FILL_MAX);

   // qualifying with rst keeps Y low for the whole time reset is held
   assign match  = rst & accept & full & (&eq_bits);

   assign Y       = match;
   assign pattern = pattern_reg;

   // next-state logic: pattern reload, history shift and fill bookkeeping
   always_comb begin
      pattern_next = pattern_reg;
      hist_next    = hist_reg;
      fill_next    = fill_reg;
      if (pat_load) begin
         pattern_next = pat_in;
         hist_next    = '0;
         fill_next    = '0;
      end else if (accept) begin
         hist_next = window[SEQ_LEN-2:0];
         if (match && (OVERLAP == 1'b0)) begin
            // non-overlapping: the next match needs SEQ_LEN fresh bits
            fill_next = '0;
         end else if (!full) begin
            fill_next = fill_reg + 1'b1;
         end
      end
   end

   // detector state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pattern_reg <= SEQ_INIT;
         hist_reg    <= '0;
         fill_reg    <= '0;
      end else begin
         pattern_reg <= pattern_next;
         hist_reg    <= hist_next;
         fill_reg    <= fill_next;
      end
   end

`ifdef SEQ_DET_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   // saturating count of match cycles; a clear beats a simultaneous match
   always_comb begin
      cnt_next = cnt_reg;
      if (cnt_clr) begin
         cnt_next = '0;
      end else if (match && (cnt_reg != {CNT_W{1'b1}})) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   // match counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign match_cnt = cnt_reg;
`else
   // counter compiled out: clear input has no effect
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param
// Three detector instances share one stimulus stream: default overlapping,
// non-overlapping, and overlapping with a 2-bit counter. Every instance is
// checked against a bit-history reference model each cycle, plus directed
// expectations for the documented scenarios.

module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       x = 1'b0;
   logic       x_valid = 1'b0;
   logic       pat_load = 1'b0;
   logic [3:0] pat_in = 4'b0000;
   logic       cnt_clr = 1'b0;

   logic       y0, y1, y2;
   logic [3:0] pat0, pat1, pat2;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;

   int total = 0;
   int bad   = 0;

   // reference model state per instance
   int nb   [3];   // accepted bits since last clear
   int sh   [3];   // recent accepted bits, newest in bit 0
   int pat  [3];
   int cnt  [3];
   int cmax [3] = '{255, 255, 3};
   int ov   [3] = '{1, 0, 1};

   logic [31:0] yh0, yh1, yh2;  // observed Y history, newest in bit 0

   seq_detector_param #(.SEQ_LEN(4), .SEQ_INIT(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
      .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .pat_load(pat_load),
      .pat_in(pat_in), .cnt_clr(cnt_clr), .Y(y0), .pattern(pat0), .match_cnt(cnt0));

   seq_detector_param #(.SEQ_LEN(4), .SEQ_INIT(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
      .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .pat_load(pat_load),
      .pat_in(pat_in), .cnt_clr(cnt_clr), .Y(y1), .pattern(pat1), .match_cnt(cnt1));

   seq_detector_param #(.SEQ_LEN(4), .SEQ_INIT(4'b1010), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .pat_load(pat_load),
      .pat_in(pat_in), .cnt_clr(cnt_clr), .Y(y2), .pattern(pat2), .match_cnt(cnt2));

   always #5 clk = ~clk;

   function automatic logic get_y(input int d);
      case (d)
         0:       return y0;
         1:       return y1;
         default: return y2;
      endcase
   endfunction

   function automatic logic [3:0] get_pat(input int d);
      case (d)
         0:       return pat0;
         1:       return pat1;
         default: return pat2;
      endcase
   endfunction

   function automatic logic [7:0] get_cnt(input int d);
      case (d)
         0:       return cnt0;
         1:       return cnt1;
         default: return {6'b0, cnt2};
      endcase
   endfunction

   function automatic int exp_cnt_if_en(input int v);
`ifdef SEQ_DET_MATCH_CNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         nb[d] = 0; sh[d] = 0; pat[d] = 4'b1010; cnt[d] = 0;
      end
      yh0 = '0; yh1 = '0; yh2 = '0;
   endtask

   // hold reset for one clock edge and check the reset state
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; x = 1'b0; x_valid = 1'b1; pat_load = 1'b0; cnt_clr = 1'b0;
      model_reset();
      #1;
      for (int d = 0; d < 3; d++) begin
         total++;
         if (get_y(d) !== 1'b0) begin
            bad++; $display("FAIL reset_y dut%0d: got %b want 0", d, get_y(d));
         end
         total++;
         if (get_pat(d) !== 4'b1010) begin
            bad++; $display("FAIL reset_pattern dut%0d: got %b want 1010", d, get_pat(d));
         end
         total++;
         if (get_cnt(d) !== 8'd0) begin
            bad++; $display("FAIL reset_cnt dut%0d: got %0d want 0", d, get_cnt(d));
         end
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1; x_valid = 1'b0;
   endtask

   // one clock of stimulus; Y checked before the edge, registers after it
   task automatic step(input logic xv, input logic xval, input logic ld,
                       input logic [3:0] pin, input logic clr);
      int  win;
      int  ey;
      int  acc;
      @(negedge clk);
      x = xv; x_valid = xval; pat_load = ld; pat_in = pin; cnt_clr = clr;
      #1;
      for (int d = 0; d < 3; d++) begin
         acc = (xval && !ld) ? 1 : 0;
         win = ((sh[d] << 1) | int'(xv)) & 15;
         ey  = (acc == 1 && nb[d] >= 3 && win == pat[d]) ? 1 : 0;
         total++;
         if (get_y(d) !== ey[0]) begin
            bad++;
            $display("FAIL y dut%0d: got %b want %0d (x=%b v=%b ld=%b pat=%h)",
                     d, get_y(d), ey, xv, xval, ld, pat[d]);
         end
         if (ld) begin
            pat[d] = int'(pin); nb[d] = 0; sh[d] = 0;
         end else if (acc == 1) begin
            sh[d] = win & 7;
            if (ey == 1 && ov[d] == 0) nb[d] = 0;
            else nb[d] = nb[d] + 1;
         end
         if (clr) cnt[d] = 0;
         else if (ey == 1 && cnt[d] < cmax[d]) cnt[d] = cnt[d] + 1;
      end
      yh0 = {yh0[30:0], y0};
      yh1 = {yh1[30:0], y1};
      yh2 = {yh2[30:0], y2};
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         total++;
         if (get_pat(d) !== pat[d][3:0]) begin
            bad++; $display("FAIL pattern dut%0d: got %b want %b", d, get_pat(d), pat[d][3:0]);
         end
         total++;
         if (get_cnt(d) !== 8'(exp_cnt_if_en(cnt[d]))) begin
            bad++; $display("FAIL match_cnt dut%0d: got %0d want %0d", d, get_cnt(d), exp_cnt_if_en(cnt[d]));
         end
      end
   endtask

   task automatic send(input logic xv);
      step(xv, 1'b1, 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_overlap();
      do_reset();
      for (int i = 0; i < 6; i++) send(i % 2 == 0);
      total++;
      if (yh0 !== 32'b000101) begin
         bad++; $display("FAIL overlap_y6: got %b want 000101", yh0[5:0]);
      end
      total++;
      if (cnt0 !== 8'(exp_cnt_if_en(2))) begin
         bad++; $display("FAIL overlap_cnt: got %0d want %0d", cnt0, exp_cnt_if_en(2));
      end
      send(1'b1); send(1'b0);
      total++;
      if (yh0 !== 32'b00010101) begin
         bad++; $display("FAIL overlap_y8: got %b want 00010101", yh0[7:0]);
      end
      total++;
      if (yh1 !== 32'b00010001) begin
         bad++; $display("FAIL nonoverlap_y8: got %b want 00010001", yh1[7:0]);
      end
   endtask

   task automatic test_bubbles();
      do_reset();
      send(1'b1); send(1'b0);
      step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
      step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
      send(1'b1); send(1'b0);
      total++;
      if (yh0 !== 32'b0000001) begin
         bad++; $display("FAIL bubbles_y: got %b want 0000001", yh0[6:0]);
      end
      total++;
      if (yh1 !== 32'b0000001) begin
         bad++; $display("FAIL bubbles_y_nonoverlap: got %b want 0000001", yh1[6:0]);
      end
   endtask

   task automatic test_load();
      do_reset();
      send(1'b1); send(1'b0); send(1'b1);
      step(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0);
      total++;
      if (pat0 !== 4'b0110) begin
         bad++; $display("FAIL load_pattern: got %b want 0110", pat0);
      end
      send(1'b0); send(1'b1); send(1'b1); send(1'b0);
      total++;
      if (yh0 !== 32'b00000001) begin
         bad++; $display("FAIL load_y: got %b want 00000001", yh0[7:0]);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      send(1'b1); send(1'b0); send(1'b1);
      do_reset();
      send(1'b0); send(1'b1); send(1'b0); send(1'b1); send(1'b0);
      total++;
      if (yh0 !== 32'b00001) begin
         bad++; $display("FAIL midreset_y: got %b want 00001", yh0[4:0]);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 12; i++) send(i % 2 == 0);
      total++;
      if (yh0 !== 32'b000101010101) begin
         bad++; $display("FAIL sat_y: got %b want 000101010101", yh0[11:0]);
      end
      total++;
      if (cnt2 !== 2'(exp_cnt_if_en(3))) begin
         bad++; $display("FAIL sat_cnt2: got %0d want %0d", cnt2, exp_cnt_if_en(3));
      end
      total++;
      if (cnt0 !== 8'(exp_cnt_if_en(5))) begin
         bad++; $display("FAIL sat_cnt0: got %0d want %0d", cnt0, exp_cnt_if_en(5));
      end
      send(1'b1);
      step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
      total++;
      if (yh0[0] !== 1'b1) begin
         bad++; $display("FAIL clr_match_y: got %b want 1", yh0[0]);
      end
      total++;
      if (cnt0 !== 8'd0 || cnt2 !== 2'd0) begin
         bad++; $display("FAIL clr_cnt: got %0d/%0d want 0/0", cnt0, cnt2);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 150) == 0) begin
            do_reset();
         end else begin
            step(1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 40) == 0,
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 30) == 0);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      test_reset();
      test_overlap();
      test_bubbles();
      test_load();
      test_mid_reset();
      test_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
